// File: rtl/keypad_debounce_scanner.sv
// keypad_debounce_scanner: drives keypad rows, samples columns and debounces whole
// scan frames into one key_valid strobe per physical press.
module keypad_debounce_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] col_meta_q, col_sync_q, row_q, row_d, first_col;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic [2:0] slot_sum;
  logic [7:0] frame_code_q, frame_code_d, code_now, cand_q, cand_d, key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic scan_tick, frame_done, res_none, res_single, accept;
  assign scan_tick  = div_cnt_q == CW'(SCAN_DIV - 1);
  assign frame_done = scan_tick && row_q[0];
  assign first_col  = col_sync_q & (~col_sync_q + 4'd1);
  assign slot_sum   = 3'(hit_cnt_q) + 3'(col_sync_q[0]) + 3'(col_sync_q[1]) + 3'(col_sync_q[2]) + 3'(col_sync_q[3]);
  assign code_now   = (hit_cnt_q == 2'd0) ? {first_col, row_q} : frame_code_q;
  assign res_none   = slot_sum == 3'd0;
  assign res_single = slot_sum == 3'd1;
  assign db_inc     = db_cnt_q + DW'(1);
  always_comb begin
    div_cnt_d    = scan_tick ? '0 : div_cnt_q + CW'(1);
    row_d        = scan_tick ? {row_q[0], row_q[3:1]} : row_q;
    hit_cnt_d    = frame_done ? 2'd0 : scan_tick ? (slot_sum >= 3'd2 ? 2'd2 : slot_sum[1:0]) : hit_cnt_q;
    frame_code_d = frame_done ? 8'h00 : scan_tick ? code_now : frame_code_q;
  end
  // Debounce decisions are taken only on the frame-completing tick.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    if (frame_done)
      case (state_q)
        IDLE: if (res_single) begin
          cand_d   = code_now;
          db_cnt_d = DW'(1);
          state_d  = CONFIRM;
          accept   = DEBOUNCE_SCANS == 1;
        end
        CONFIRM: if (!res_single) state_d = IDLE;
          else if (code_now == cand_q) begin
            db_cnt_d = db_inc;
            accept   = db_inc == DW'(DEBOUNCE_SCANS);
          end else begin
            cand_d   = code_now;
            db_cnt_d = DW'(1);
          end
        HELD: if (res_none) begin
          db_cnt_d   = DW'(1);
          state_d    = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
          key_held_d = DEBOUNCE_SCANS != 1;
        end
        RELEASE: if (!res_none) state_d = HELD;
          else begin
            db_cnt_d = db_inc;
            if (db_inc == DW'(DEBOUNCE_SCANS)) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end
        default: state_d = IDLE;
      endcase
    if (accept) begin
      key_code_d  = cand_d;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      state_d     = HELD;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_meta_q   <= '0;
      col_sync_q   <= '0;
      div_cnt_q    <= '0;
      row_q        <= 4'b1000;
      hit_cnt_q    <= '0;
      frame_code_q <= '0;
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      col_meta_q   <= col_in;
      col_sync_q   <= col_meta_q;
      div_cnt_q    <= div_cnt_d;
      row_q        <= row_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_code_q <= frame_code_d;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      cand_q       <= cand_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
    end
  assign row_out   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule
